thermal_regulator: RTL and testbench

Upstream control stage for CoolHeatSystem. It accepts temperature samples over a valid/ready handshake, filters them with a 4-sample moving average, and runs a hysteresis FSM (IDLE/COOLING/HEATING) with a minimum-dwell timer. It drives the `chs_conf` and `speed` buses that CoolHeatSystem consumes directly.

---
 rtl/chs_pkg.sv | 29 ++
 rtl/moving_avg4.sv | 46 ++++
 rtl/thermal_regulator.sv | 156 +++++++++++++++
 tb/tb_thermal_regulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chs_pkg.sv
// Shared types and constants for the CoolHeatSystem control path.
// Holds the FSM state type, chs_conf field positions and the divide-by-3 helper.
package chs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COOLING = 2'd1,
        HEATING = 2'd2
    } state_t;

    localparam int AVG_DEPTH = 4;

    localparam int CONF_EN_BIT   = 7;
    localparam int CONF_MODE_BIT = 6;
    localparam int CONF_PWR_MSB  = 5;
    localparam int CONF_PWR_LSB  = 2;
    localparam int CONF_TAG_MSB  = 1;
    localparam int CONF_TAG_LSB  = 0;

    localparam logic [1:0] CONF_TAG = 2'b11;

    // floor(v/3) via the reciprocal 683/2048; this is exact for every reachable sum (<= 765).
    function automatic logic [7:0] div3(input logic [9:0] v);
        logic [20:0] p;
        p = {11'd0, v} * 21'd683;
        return 8'(p >> 11);
    endfunction

endpackage

// File: rtl/moving_avg4.sv
// Four-sample moving average: history shift register, running sum and fill count.
// avg is combinational from the registered sum, so it is valid the cycle after in_valid.
module moving_avg4
    import chs_pkg::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [7:0] avg
);

    localparam logic [2:0] FILL_MAX = 3'(AVG_DEPTH);

    logic [3:0][7:0] r_hist;
    logic [9:0]      r_sum;
    logic [2:0]      r_fill;

    // History, running sum and saturating fill count; empty slots read as 0 so the sum stays exact.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_hist <= '0;
            r_sum  <= 10'd0;
            r_fill <= 3'd0;
        end else if (in_valid) begin
            r_hist <= {r_hist[2:0], in_data};
            r_sum  <= r_sum + {2'b00, in_data} - {2'b00, r_hist[3]};
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 3'd1;
            end
        end
    end

    // Divide by the number of samples actually held.
    always_comb begin
        avg = 8'd0;
        case (r_fill)
            3'd1:    avg = r_sum[7:0];
            3'd2:    avg = r_sum[8:1];
            3'd3:    avg = div3(r_sum);
            3'd4:    avg = r_sum[9:2];
            default: avg = 8'd0;
        endcase
    end

endmodule

// File: rtl/thermal_regulator.sv
// Temperature regulator: sample handshake, 3-stage pipeline, hysteresis FSM with
// minimum dwell, and registered chs_conf/speed drive for CoolHeatSystem.
module thermal_regulator
    import chs_pkg::*;
#(
    parameter int DWELL_CYCLES = 1024,
    parameter int SPEED_GAIN   = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       temp_valid,
    input  logic [7:0] temp_data,
    output logic       temp_ready,
    input  logic [7:0] setpoint,
    input  logic [3:0] hyst,
    output logic [7:0] chs_conf,
    output logic [7:0] speed,
    output logic       conf_update
);

    localparam logic [10:0] DWELL_LOAD = 11'(DWELL_CYCLES - 1);
    localparam logic [12:0] GAIN       = 13'(SPEED_GAIN);

    logic        r_ready;
    logic        r_s1;
    logic        r_s2;
    logic [7:0]  r_sp;
    logic [3:0]  r_hyst;
    logic [7:0]  r_avg;
    state_t      r_state;
    logic [10:0] r_dwell;
    logic [7:0]  r_conf;
    logic [7:0]  r_speed;
    logic        r_upd;

    logic              w_accept;
    logic [7:0]        w_avg;
    logic signed [9:0] w_err;
    logic signed [9:0] w_hyst_s;
    logic [9:0]        w_abs;
    logic [3:0]        w_pwr;
    logic [12:0]       w_prod;
    logic [7:0]        w_speed;
    logic [7:0]        w_conf;
    state_t            w_next;

    assign w_accept    = temp_valid && r_ready;
    assign temp_ready  = r_ready;
    assign chs_conf    = r_conf;
    assign speed       = r_speed;
    assign conf_update = r_upd;

    moving_avg4 u_avg (
        .clk      (clk),
        .arst     (arst),
        .in_valid (w_accept),
        .in_data  (temp_data),
        .avg      (w_avg)
    );

    // 10-bit signed so setpoint+hyst up to 270 never wraps.
    assign w_err    = $signed({2'b00, r_avg}) - $signed({2'b00, r_sp});
    assign w_hyst_s = $signed({6'd0, r_hyst});

    // Next state from the hysteresis band and dwell expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_err > w_hyst_s) begin
                    w_next = COOLING;
                end else if (w_err < -w_hyst_s) begin
                    w_next = HEATING;
                end else begin
                    w_next = IDLE;
                end
            end
            COOLING: begin
                if ((w_err <= 10'sd0) && (r_dwell == 11'd0)) begin
                    w_next = IDLE;
                end else begin
                    w_next = COOLING;
                end
            end
            HEATING: begin
                if ((w_err >= 10'sd0) && (r_dwell == 11'd0)) begin
                    w_next = IDLE;
                end else begin
                    w_next = HEATING;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Output mapping for the state being entered, saturating power and speed.
    always_comb begin
        w_abs   = w_err[9] ? 10'(-w_err) : 10'(w_err);
        w_pwr   = (w_abs > 10'd15) ? 4'd15 : w_abs[3:0];
        w_prod  = {3'd0, w_abs} * GAIN;
        w_speed = 8'd0;
        w_conf  = 8'd0;
        w_conf[CONF_TAG_MSB:CONF_TAG_LSB] = CONF_TAG;
        if (w_next != IDLE) begin
            w_conf[CONF_EN_BIT]                 = 1'b1;
            w_conf[CONF_MODE_BIT]               = (w_next == COOLING);
            w_conf[CONF_PWR_MSB:CONF_PWR_LSB]   = w_pwr;
            w_speed = (w_prod > 13'd255) ? 8'hFF : w_prod[7:0];
        end else begin
            w_speed = 8'd0;
        end
    end

    // Handshake, pipeline stages, FSM, dwell timer and registered outputs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_ready <= 1'b1;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_sp    <= 8'd0;
            r_hyst  <= 4'd0;
            r_avg   <= 8'd0;
            r_state <= IDLE;
            r_dwell <= 11'd0;
            r_conf  <= 8'd0;
            r_speed <= 8'd0;
            r_upd   <= 1'b0;
        end else begin
            r_s1  <= w_accept;
            r_s2  <= r_s1;
            r_upd <= 1'b0;
            if (w_accept) begin
                r_ready <= 1'b0;
                r_sp    <= setpoint;
                r_hyst  <= hyst;
            end else if (r_s2) begin
                r_ready <= 1'b1;
            end
            if (r_s1) begin
                r_avg <= w_avg;
            end
            if (r_s2) begin
                r_state <= w_next;
                r_conf  <= w_conf;
                r_speed <= w_speed;
                r_upd   <= (w_conf != r_conf) || (w_speed != r_speed);
            end
            if (r_s2 && (r_state == IDLE) && (w_next != IDLE)) begin
                r_dwell <= DWELL_LOAD;
            end else if (r_dwell != 11'd0) begin
                r_dwell <= r_dwell - 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_thermal_regulator.sv
// Self-checking bench for thermal_regulator: per-cycle comparison against an
// edge-counting behavioural model plus hand-computed literal expectations.
module tb_thermal_regulator;

    localparam int DWELL = 1024;
    localparam int M_IDLE = 0, M_COOL = 1, M_HEAT = 2;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       temp_valid = 1'b0;
    logic [7:0] temp_data = 8'd0;
    logic [7:0] setpoint = 8'd0;
    logic [3:0] hyst = 4'd0;
    logic       temp_ready;
    logic [7:0] chs_conf;
    logic [7:0] speed;
    logic       conf_update;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;

    thermal_regulator dut (
        .clk         (clk),
        .arst        (arst),
        .temp_valid  (temp_valid),
        .temp_data   (temp_data),
        .temp_ready  (temp_ready),
        .setpoint    (setpoint),
        .hyst        (hyst),
        .chs_conf    (chs_conf),
        .speed       (speed),
        .conf_update (conf_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted samples, edge counter, state as plain integers.
    int         q[$];
    int         m_sp, m_hy, m_state, m_entry, m_acc = -100, e = 0;
    bit         m_pend = 1'b0;
    logic [7:0] m_conf = 8'd0, m_speed = 8'd0;
    logic       m_upd = 1'b0;

    initial begin
        bit acc;
        int s, avg, err, mag, nst, pwr, spd;
        logic [7:0] nconf;
        forever begin
            @(posedge clk or negedge arst);
            if (!arst) begin
                q.delete();
                m_state = M_IDLE; m_conf = 8'd0; m_speed = 8'd0; m_upd = 1'b0; m_pend = 1'b0;
            end else begin
                e++;
                acc = temp_valid && !m_pend;
                m_upd = 1'b0;
                if (m_pend && e == m_acc + 2) begin
                    s = 0;
                    foreach (q[i]) s += q[i];
                    avg = s / q.size();
                    err = avg - m_sp;
                    nst = m_state;
                    case (m_state)
                        M_IDLE: if (avg > m_sp + m_hy) nst = M_COOL;
                                else if (avg < m_sp - m_hy) nst = M_HEAT;
                        M_COOL: if (avg <= m_sp && e - m_entry >= DWELL) nst = M_IDLE;
                        M_HEAT: if (avg >= m_sp && e - m_entry >= DWELL) nst = M_IDLE;
                        default: nst = M_IDLE;
                    endcase
                    if (m_state == M_IDLE && nst != M_IDLE) m_entry = e;
                    mag = (err < 0) ? -err : err;
                    pwr = (mag > 15) ? 15 : mag;
                    spd = (mag * 16 > 255) ? 255 : mag * 16;
                    if (nst == M_IDLE) begin
                        nconf = 8'h03; spd = 0;
                    end else begin
                        nconf = {1'b1, (nst == M_COOL), 4'(pwr), 2'b11};
                    end
                    m_upd = (nconf != m_conf) || (8'(spd) != m_speed);
                    m_conf = nconf; m_speed = 8'(spd); m_state = nst; m_pend = 1'b0;
                end
                if (acc) begin
                    q.push_back(int'(temp_data));
                    if (q.size() > 4) void'(q.pop_front());
                    m_sp = int'(setpoint); m_hy = int'(hyst); m_acc = e; m_pend = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("ready", temp_ready, !m_pend);
        chk("chs_conf", chs_conf, m_conf);
        chk("speed", speed, m_speed);
        chk("conf_update", conf_update, m_upd);
        if (conf_update === 1'b1) upd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        temp_valid = 1'b0;
        arst = 1'b0;
        tick(2);
        arst = 1'b1;
        tick(1);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] sp, input logic [3:0] h);
        int n = 0;
        temp_data = d; setpoint = sp; hyst = h; temp_valid = 1'b1;
        while (!temp_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 16'd0, 16'd1);
        tick(1);
        temp_valid = 1'b0;
    endtask

    initial begin
        int accs;
        tick(1);
        chk("rst_ready", temp_ready, 1'b1);
        chk("rst_conf", chs_conf, 8'h00);
        chk("rst_speed", speed, 8'h00);
        arst = 1'b1;
        tick(1);

        // Single in-band sample: IDLE, ready low for two cycles
        send(8'd25, 8'd25, 4'd2);
        chk("busy0", temp_ready, 1'b0);
        tick(1);
        chk("busy1", temp_ready, 1'b0);
        tick(1);
        chk("ready_back", temp_ready, 1'b1);
        chk("idle_conf", chs_conf, 8'h03);
        chk("idle_speed", speed, 8'h00);
        chk("idle_upd", conf_update, 1'b1);
        tick(1);
        chk("upd_one_cycle", conf_update, 1'b0);

        // Four samples of 40 -> cooling, one update pulse
        do_reset();
        upd_cnt = 0;
        repeat (4) send(8'd40, 8'd25, 4'd2);
        tick(5);
        chk("cool_conf", chs_conf, 8'hFF);
        chk("cool_speed", speed, 8'd240);
        chk("cool_upd_cnt", upd_cnt, 1);

        // Heating, held by dwell, then released after expiry
        do_reset();
        repeat (4) send(8'd10, 8'd25, 4'd2);
        tick(4);
        chk("heat_conf", chs_conf, 8'hBF);
        chk("heat_speed", speed, 8'd240);
        repeat (4) send(8'd30, 8'd25, 4'd2);
        tick(4);
        chk("heat_dwell_conf", chs_conf, 8'h97);
        chk("heat_dwell_speed", speed, 8'd80);
        tick(DWELL + 10);
        send(8'd30, 8'd25, 4'd2);
        tick(4);
        chk("heat_exit_conf", chs_conf, 8'h03);
        chk("heat_exit_speed", speed, 8'd0);

        // In-band averages, then 29s push avg to 28 -> cooling power 3
        do_reset();
        send(8'd26, 8'd25, 4'd2);
        send(8'd27, 8'd25, 4'd2);
        tick(4);
        chk("band_conf", chs_conf, 8'h03);
        repeat (2) send(8'd29, 8'd25, 4'd2);
        tick(4);
        chk("band27_conf", chs_conf, 8'h03);
        send(8'd29, 8'd25, 4'd2);
        tick(4);
        chk("band_cool_conf", chs_conf, 8'hCF);
        chk("band_cool_speed", speed, 8'd48);

        // Band edges must not wrap: hi=260, lo=-5
        do_reset();
        send(8'd255, 8'd250, 4'd10);
        tick(4);
        chk("hi_nowrap", chs_conf, 8'h03);
        do_reset();
        send(8'd0, 8'd5, 4'd10);
        tick(4);
        chk("lo_nowrap", chs_conf, 8'h03);

        // Continuous valid: one acceptance every three cycles
        do_reset();
        accs = 0;
        setpoint = 8'd100; hyst = 4'd15; temp_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            temp_data = 8'(60 + i);
            @(negedge clk);
            if (temp_ready) accs++;
            tick(1);
        end
        temp_valid = 1'b0;
        chk("accept_rate", accs, 10);
        tick(6);

        // Reset in the middle of processing clears history
        do_reset();
        send(8'd200, 8'd25, 4'd2);
        tick(4);
        send(8'd50, 8'd25, 4'd2);
        arst = 1'b0;
        #1;
        chk("midrst_ready", temp_ready, 1'b1);
        chk("midrst_conf", chs_conf, 8'h00);
        chk("midrst_speed", speed, 8'h00);
        tick(2);
        arst = 1'b1;
        tick(1);
        send(8'd100, 8'd90, 4'd5);
        tick(4);
        chk("post_rst_conf", chs_conf, 8'hEB);
        chk("post_rst_speed", speed, 8'd160);

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
